bcd_countdown: RTL

Nibble-serial BCD down-counter for the DE1-SoC demo timers. It decrements a packed multi-digit BCD value by one per accepted enable request and supports a parallel load with BCD validation. It flags the zero count for countdown displays. It is the counting-down counterpart of the team's BCD up-counter and drives the same seven-segment display path.

---
 rtl/bcd_countdown.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bcd_countdown.sv
// Nibble-serial BCD down-counter with validated parallel load and a zero flag.
// Define BCD_COUNTDOWN_WRAP_EN to let a decrement at 000000 wrap to 999999 instead of saturating.
module bcd_countdown #(
  parameter int COUNTER_DIGITS = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*COUNTER_DIGITS-1:0]   loadValue,
  output logic                          ready,
  output logic [4*COUNTER_DIGITS-1:0]   countValue,
  output logic                          zero,
  output logic                          loadError
);

  localparam int COUNTER_BITWIDTH     = 4 * COUNTER_DIGITS;
  localparam int DIGIT_INDEX_BITWIDTH = $clog2(COUNTER_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READY     = 2'd1,
    DECREMENT = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t                          state_r;
  logic [COUNTER_BITWIDTH-1:0]     work_r;
  logic [DIGIT_INDEX_BITWIDTH-1:0] digit_ptr_r;

  logic [3:0]                      cur_digit_s;
  logic [3:0]                      new_digit_s;
  logic [COUNTER_BITWIDTH-1:0]     work_next_s;
  logic [DIGIT_INDEX_BITWIDTH-1:0] ptr_inc_s;
  logic                            ptr_done_s;
  logic                            dec_start_s;

  // True when every nibble of the packed value is a legal BCD digit.
  function automatic logic bcd_valid(input logic [COUNTER_BITWIDTH-1:0] value);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < COUNTER_DIGITS; i++) begin
      ok = ok & (value[4*i +: 4] <= 4'd9);
    end
    return ok;
  endfunction

  // Borrow step on a single BCD digit: 0 borrows and becomes 9.
  function automatic logic [3:0] bcd_digit_dec(input logic [3:0] digit);
    return (digit == 4'd0) ? 4'd9 : (digit - 4'd1);
  endfunction

  // Select the digit under the pointer and build the rewritten working value.
  always_comb begin
    cur_digit_s = 4'd0;
    for (int i = 0; i < COUNTER_DIGITS; i++) begin
      cur_digit_s = (digit_ptr_r == DIGIT_INDEX_BITWIDTH'(i)) ? work_r[4*i +: 4] : cur_digit_s;
    end
    new_digit_s = bcd_digit_dec(cur_digit_s);
    work_next_s = work_r;
    for (int i = 0; i < COUNTER_DIGITS; i++) begin
      work_next_s[4*i +: 4] = (digit_ptr_r == DIGIT_INDEX_BITWIDTH'(i)) ? new_digit_s : work_r[4*i +: 4];
    end
    ptr_inc_s  = digit_ptr_r + DIGIT_INDEX_BITWIDTH'(1);
    ptr_done_s = (ptr_inc_s == DIGIT_INDEX_BITWIDTH'(COUNTER_DIGITS));
  end

  // Decide whether an accepted enable starts a borrow chain.
  always_comb begin
`ifdef BCD_COUNTDOWN_WRAP_EN
    dec_start_s = 1'b1;
`else
    dec_start_s = (work_r != {COUNTER_BITWIDTH{1'b0}});
`endif
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      ready       <= 1'b0;
      countValue  <= {COUNTER_BITWIDTH{1'b0}};
      work_r      <= {COUNTER_BITWIDTH{1'b0}};
      zero        <= 1'b1;
      loadError   <= 1'b0;
      digit_ptr_r <= {DIGIT_INDEX_BITWIDTH{1'b0}};
    end else begin
      loadError <= 1'b0;
      case (state_r)
        IDLE: begin
          ready <= 1'b1;
          // Requests re-arm only after enable has been seen low here.
          if (!enable) begin
            state_r <= READY;
          end else begin
            state_r <= IDLE;
          end
        end
        READY: begin
          if (load) begin
            state_r <= IDLE;
            if (bcd_valid(loadValue)) begin
              work_r     <= loadValue;
              countValue <= loadValue;
              zero       <= (loadValue == {COUNTER_BITWIDTH{1'b0}});
            end else begin
              loadError <= 1'b1;
            end
          end else if (enable) begin
            if (dec_start_s) begin
              ready       <= 1'b0;
              digit_ptr_r <= {DIGIT_INDEX_BITWIDTH{1'b0}};
              state_r     <= DECREMENT;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= READY;
          end
        end
        DECREMENT: begin
          work_r <= work_next_s;
          if (cur_digit_s == 4'd0) begin
            digit_ptr_r <= ptr_inc_s;
            if (ptr_done_s) begin
              state_r <= UPDATE;
            end else begin
              state_r <= DECREMENT;
            end
          end else begin
            state_r <= UPDATE;
          end
        end
        UPDATE: begin
          // countValue only ever sees the finished value, never a partial borrow chain.
          countValue <= work_r;
          zero       <= (work_r == {COUNTER_BITWIDTH{1'b0}});
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
